mem_responder: RTL
==================

# mem_responder

Shared-memory responder sitting behind the arbiter: the target end of the requester valid/ready protocol. It accepts one granted request at a time (read or write, tagged with the requester index), performs the access on an internal word array after a fixed latency, and returns a response beat that is held until the requester consumes it. One transaction is outstanding at most, so the arbiter's grant stays stable for the whole transaction.

## Interface

Parameters:
- DATA_WIDTH, 4, word width
- ADDR_WIDTH, 8, address width; array depth is 2**ADDR_WIDTH
- NUM_REQUESTERS, 3, number of arbitrated requesters; ID_WIDTH = max(1, clog2(NUM_REQUESTERS))
- LATENCY, 2, access latency in cycles; legal range 1..15

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- valid  in  1  request present
- ready  out  1  responder can accept a request
- read_writeBar  in  1  1 = read, 0 = write
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data; ignored on reads
- req_id  in  ID_WIDTH  index of the granted requester
- rvalid  out  1  response present
- rready  in  1  requester accepts the response
- rdata  out  DATA_WIDTH  read data; 0 for write responses
- rid  out  ID_WIDTH  req_id captured with the request
- rerr  out  1  parity error on a read (see Configuration)

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: ready = 1. On valid && ready, capture addr, wdata, read_writeBar and req_id; load the latency counter with LATENCY-1; go to BUSY.
- BUSY: ready = 0. The counter decrements each cycle. When the counter is 0:
  - A write updates the array.
  - A read loads rdata from the array.
  - rid is loaded from the captured req_id.
  - The FSM goes to RESP.
- RESP: rvalid = 1, ready = 0. rdata, rid and rerr are held stable while rvalid && !rready. On rvalid && rready, go to IDLE.
- Every accepted request, write or read, produces exactly one response beat.
- Inputs are sampled only at the accept edge. Later changes to addr, wdata or req_id have no effect.
- Read after a write to the same address returns the new data.
- Array contents are not reset. Reading a never-written address returns undefined data.
- Counter width is 4 bits. LATENCY = 1 means the access happens in the first BUSY cycle.

## Timing

- Reset values: ready = 1, rvalid = 0, rdata = 0, rid = 0, rerr = 0; FSM in IDLE; counter at 0.
- Handshake at edge T means rvalid is high after edge T+LATENCY.
- If rready is already high, the response completes at edge T+LATENCY+1, and ready is high after that edge.
- Minimum transaction period is LATENCY+2 cycles.
- ready is never high in the same cycle as rvalid; there is no overlap of request and response.
- If valid is high while ready = 0, nothing is captured. The requester must hold the request until it sees ready.
- rvalid high with rready low: the beat is held indefinitely.
- Reset mid-operation: the transaction is abandoned, and all outputs take their reset values on the next edge.
  - A write not yet performed when rst is sampled high is not performed.
  - A write already performed stays in the array.
- rst has priority over every other event in the same cycle.

## Configuration

- Macro: MEM_RESPONDER_PARITY_EN.
- Defined:
  - Each array word stores DATA_WIDTH+1 bits, the extra bit being even parity of wdata, computed at write time.
  - On a read, rerr = 1 if the recomputed parity mismatches the stored bit. rerr is 0 for writes.
  - A read of a never-written word may flag rerr.
- Undefined: the array is DATA_WIDTH wide and rerr is tied to 0.
- All other behaviour and timing are identical in both builds.

## Structure

- Shared package mem_resp_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - the ID_WIDTH and counter-width localparam functions
  - a parity helper function, used only when MEM_RESPONDER_PARITY_EN is defined
- One sub-module, mem_resp_array: synchronous-write, combinational-read storage with word width selected by the macro.
- mem_responder contains the FSM, the capture registers and the response registers.

## Test plan

- Reset → ready=1, rvalid=0, rdata=0, rid=0, rerr=0 on the first edge after rst is released.
- Write addr=0x10, wdata=0xA, req_id=2, LATENCY=2, rready=1 → rvalid after edge T+2 with rdata=0 and rid=2; ready returns after edge T+3. Then read 0x10 with req_id=1 → rdata=0xA, rid=1.
- Read response with rready held low 5 cycles → rvalid, rdata and rid stable for all 5 cycles; ready=0 throughout. A valid pulse during this window is not captured.
- Assert rst during BUSY of a write to 0x20 (old value 0x3, new value 0xC) → outputs return to reset values next edge; a following read of 0x20 returns 0x3.
- Back-to-back requests with LATENCY=1 and valid held high → one accept every 3 cycles; responses in order with the correct rid.
- With MEM_RESPONDER_PARITY_EN: write 0x5, force-flip the stored parity bit, then read → rerr=1 and rdata=0x5. A clean read of the same word → rerr=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state enum, width helpers and parity function for mem_responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_width();
    return 4;
  endfunction
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: sync-write, comb-read word array; MEM_RESPONDER_PARITY_EN adds a stored parity bit
module mem_resp_array import mem_resp_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rerr
);
`ifdef MEM_RESPONDER_PARITY_EN
  logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) if (we) mem[addr] <= {parity(64'(wdata)), wdata};
  assign rdata = mem[addr][DATA_WIDTH-1:0];
  assign rerr = parity(64'(rdata)) ^ mem[addr][DATA_WIDTH];
`else
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
  assign rerr = 1'b0;
`endif
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with fixed latency and held response beat
module mem_responder import mem_resp_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQUESTERS = 3,
  parameter int LATENCY = 2,
  localparam int ID_WIDTH = id_width(NUM_REQUESTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  read_writeBar,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic                  rerr
);
  localparam int CW = cnt_width();
  state_t state;
  logic [CW-1:0] cnt;
  logic rw_q, mem_rerr, fire;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, mem_rdata;
  logic [ID_WIDTH-1:0] id_q;
  // rst gates the write so an abandoned transaction never reaches the array
  assign fire = !rst && state == BUSY && cnt == '0;
  mem_resp_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_arr (
    .clk(clk), .we(fire && !rw_q), .addr(addr_q), .wdata(wdata_q),
    .rdata(mem_rdata), .rerr(mem_rerr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ready <= 1'b1;
      rvalid <= 1'b0;
      rdata <= '0;
      rid <= '0;
      rerr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          rw_q <= read_writeBar;
          addr_q <= addr;
          wdata_q <= wdata;
          id_q <= req_id;
          cnt <= CW'(LATENCY - 1);
          ready <= 1'b0;
          state <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          rdata <= rw_q ? mem_rdata : '0;
          rerr <= rw_q && mem_rerr;
          rid <= id_q;
          rvalid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (rready) begin
          rvalid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
